var_node_cell: RTL and testbench

VAR_NODE_CELL -- requirements
Module: var_node_cell

---
 rtl/ldpc_pkg.sv | 25 ++
 rtl/vnc_sum.sv | 32 +++
 rtl/var_node_cell.sv | 122 ++++++++++++
 tb/tb_var_node_cell.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/ldpc_pkg.sv
// Shared definitions for the LDPC variable-node datapath: FSM encoding,
// default message geometry and a width helper usable in constant expressions.
package ldpc_pkg;

    localparam int LDPC_D_WID = 8;
    localparam int LDPC_DV    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } vnc_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << r) < value) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/vnc_sum.sv
// Combinational accumulator: last check message plus (message - d_last) for
// every other branch, all sign-extended so the sum can never overflow.
module vnc_sum
    import ldpc_pkg::*;
#(
    parameter  int D_WID   = LDPC_D_WID,
    parameter  int DV      = LDPC_DV,
    localparam int ACC_WID = D_WID + clog2(2 * DV)
) (
    input  logic [DV*D_WID-1:0] dvtc,
    input  logic [D_WID-1:0]    d_last,
    output logic [ACC_WID-1:0]  acc
);

    logic signed [ACC_WID-1:0] sum_s;
    logic signed [ACC_WID-1:0] last_ext_s;
    logic        [D_WID-1:0]   slice_s;

    // Sign-extended sum over all branches
    always_comb begin
        slice_s    = dvtc[(DV-1)*D_WID +: D_WID];
        sum_s      = {{(ACC_WID-D_WID){slice_s[D_WID-1]}}, slice_s};
        last_ext_s = {{(ACC_WID-D_WID){d_last[D_WID-1]}}, d_last};
        for (int i = 0; i < DV - 1; i++) begin
            slice_s = dvtc[i*D_WID +: D_WID];
            sum_s   = sum_s + {{(ACC_WID-D_WID){slice_s[D_WID-1]}}, slice_s} - last_ext_s;
        end
    end

    assign acc = sum_s;

endmodule

// File: rtl/var_node_cell.sv
// LDPC variable-node cell: channel-LLR load, three-state update FSM and output fit.
// Define VNC_SAT_EN for symmetric saturation with a sticky sat_flag; otherwise the result wraps.
module var_node_cell
    import ldpc_pkg::*;
#(
    parameter int D_WID = LDPC_D_WID,
    parameter int DV    = LDPC_DV
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_en,
    input  logic               sin,
    input  logic [D_WID-1:0]   din,
    input  logic               upd_valid,
    output logic               upd_ready,
    input  logic [DV*D_WID-1:0] dvtc,
    input  logic [D_WID-1:0]   d_last,
    output logic [D_WID-1:0]   ram_d,
    output logic               hard_bit,
    output logic               out_valid,
    output logic               busy,
    output logic               sat_flag
);

    localparam int ACC_WID = D_WID + clog2(2 * DV);
    localparam logic signed [ACC_WID-1:0] SAT_MAX = ACC_WID'((2 ** (D_WID - 1)) - 1);
    localparam logic signed [ACC_WID-1:0] SAT_MIN = -SAT_MAX;

    vnc_state_e                state_q, state_d;
    logic signed [ACC_WID-1:0] acc_q, acc_d;
    logic        [D_WID-1:0]   ram_q, ram_d_d;
    logic                      ov_q, ov_d;
    logic                      sat_q, sat_d;
    logic        [ACC_WID-1:0] sum_s;
    logic        [D_WID:0]     fit_s;

    // Returns {clipped, value}; clipping is symmetric so -2^(D_WID-1) never appears
    function automatic logic [D_WID:0] fit(input logic signed [ACC_WID-1:0] a);
`ifdef VNC_SAT_EN
        if (a > SAT_MAX) begin
            fit = {1'b1, SAT_MAX[D_WID-1:0]};
        end else if (a < SAT_MIN) begin
            fit = {1'b1, SAT_MIN[D_WID-1:0]};
        end else begin
            fit = {1'b0, a[D_WID-1:0]};
        end
`else
        fit = {1'b0, a[D_WID-1:0]};
`endif
    endfunction

    vnc_sum #(.D_WID(D_WID), .DV(DV)) u_sum (
        .dvtc   (dvtc),
        .d_last (d_last),
        .acc    (sum_s)
    );

    assign fit_s     = fit(acc_q);
    assign upd_ready = (state_q == IDLE) && !load_en;
    assign busy      = (state_q != IDLE);
    assign hard_bit  = ram_q[D_WID-1];
    assign ram_d     = ram_q;
    assign out_valid = ov_q;
    assign sat_flag  = sat_q;

    // Next-state logic; a selected load overrides any update activity
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ram_d_d = ram_q;
        sat_d   = sat_q;
        ov_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (upd_valid && upd_ready) begin
                    acc_d   = sum_s;
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                ram_d_d = fit_s[D_WID-1:0];
                sat_d   = sat_q | fit_s[D_WID];
                ov_d    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (load_en && sin) begin
            ram_d_d = din;
            sat_d   = 1'b0;
            ov_d    = 1'b0;
            state_d = IDLE;
        end else begin
            ram_d_d = ram_d_d;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ram_q   <= '0;
            ov_q    <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ram_q   <= ram_d_d;
            ov_q    <= ov_d;
            sat_q   <= sat_d;
        end
    end

endmodule

// File: tb/tb_var_node_cell.sv
// Directed self-checking bench for var_node_cell (D_WID=8, DV=3); expectations
// follow the VNC_SAT_EN setting of the build.
module tb_var_node_cell;

    logic        clk;
    logic        reset;
    logic        load_en;
    logic        sin;
    logic [7:0]  din;
    logic        upd_valid;
    logic        upd_ready;
    logic [23:0] dvtc;
    logic [7:0]  d_last;
    logic [7:0]  ram_d;
    logic        hard_bit;
    logic        out_valid;
    logic        busy;
    logic        sat_flag;

    int checks;
    int passed;

`ifdef VNC_SAT_EN
    localparam logic [7:0] SAT_POS_EXP  = 8'd127;
    localparam logic       SAT_POS_FLAG = 1'b1;
    localparam logic [7:0] SAT_NEG_EXP  = 8'h81;
    localparam logic       SAT_NEG_FLAG = 1'b1;
`else
    localparam logic [7:0] SAT_POS_EXP  = 8'hF4;
    localparam logic       SAT_POS_FLAG = 1'b0;
    localparam logic [7:0] SAT_NEG_EXP  = 8'h82;
    localparam logic       SAT_NEG_FLAG = 1'b0;
`endif

    var_node_cell #(.D_WID(8), .DV(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .load_en   (load_en),
        .sin       (sin),
        .din       (din),
        .upd_valid (upd_valid),
        .upd_ready (upd_ready),
        .dvtc      (dvtc),
        .d_last    (d_last),
        .ram_d     (ram_d),
        .hard_bit  (hard_bit),
        .out_valid (out_valid),
        .busy      (busy),
        .sat_flag  (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; load_en = 1'b0; sin = 1'b0; din = 8'd0;
        upd_valid = 1'b0; dvtc = '0; d_last = 8'd0;
        tick(); tick();
        reset = 1'b0;
        tick();
        checks++; if (ram_d !== 8'd0) $display("FAIL reset_ram_d: got %0h want 0", ram_d); else passed++;
        checks++; if (hard_bit !== 1'b0) $display("FAIL reset_hard_bit: got %b want 0", hard_bit); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        checks++; if (sat_flag !== 1'b0) $display("FAIL reset_sat_flag: got %b want 0", sat_flag); else passed++;
        checks++; if (upd_ready !== 1'b1) $display("FAIL reset_upd_ready: got %b want 1", upd_ready); else passed++;
        load_en = 1'b1; #1;
        checks++; if (upd_ready !== 1'b0) $display("FAIL ready_with_load: got %b want 0", upd_ready); else passed++;
        load_en = 1'b0; #1;
    endtask

    task automatic run_update(input logic [23:0] v, input logic [7:0] dl,
                              input logic [7:0] exp_ram, input logic exp_sat, input string name);
        dvtc = v; d_last = dl; upd_valid = 1'b1;
        tick();
        upd_valid = 1'b0; dvtc = {3{8'h7F}}; d_last = 8'h00;
        checks++; if (busy !== 1'b1 || upd_ready !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL %s_accept: got busy=%b ready=%b ov=%b want 1 0 0", name, busy, upd_ready, out_valid); else passed++;
        tick();
        checks++; if (ram_d !== exp_ram) $display("FAIL %s_ram_d: got %0h want %0h", name, ram_d, exp_ram); else passed++;
        checks++; if (out_valid !== 1'b1) $display("FAIL %s_out_valid: got %b want 1", name, out_valid); else passed++;
        checks++; if (sat_flag !== exp_sat) $display("FAIL %s_sat_flag: got %b want %b", name, sat_flag, exp_sat); else passed++;
        checks++; if (hard_bit !== exp_ram[7]) $display("FAIL %s_hard_bit: got %b want %b", name, hard_bit, exp_ram[7]); else passed++;
        tick();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || upd_ready !== 1'b1)
            $display("FAIL %s_done: got ov=%b busy=%b ready=%b want 0 0 1", name, out_valid, busy, upd_ready); else passed++;
    endtask

    task automatic test_basic();
        run_update({8'd5, 8'd20, 8'd10}, 8'd3, 8'd29, 1'b0, "basic");
    endtask

    task automatic test_saturation();
        run_update({3{8'd100}}, 8'h9C, SAT_POS_EXP, SAT_POS_FLAG, "sat_pos");
        run_update({3{8'h80}}, 8'h7F, SAT_NEG_EXP, SAT_NEG_FLAG, "sat_neg");
    endtask

    task automatic test_load_abort();
        dvtc = {8'd5, 8'd20, 8'd10}; d_last = 8'd3; upd_valid = 1'b1;
        tick();
        upd_valid = 1'b0;
        load_en = 1'b1; sin = 1'b1; din = 8'hF9;
        tick();
        checks++; if (ram_d !== 8'hF9) $display("FAIL abort_ram_d: got %0h want f9", ram_d); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL abort_out_valid: got %b want 0", out_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else passed++;
        checks++; if (sat_flag !== 1'b0) $display("FAIL abort_sat_flag: got %b want 0", sat_flag); else passed++;
        load_en = 1'b0; sin = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || ram_d !== 8'hF9) $display("FAIL abort_after: got ov=%b ram=%0h want 0 f9", out_valid, ram_d); else passed++;
        load_en = 1'b1; sin = 1'b0; din = 8'd55;
        tick();
        checks++; if (ram_d !== 8'hF9) $display("FAIL load_nosel: got %0h want f9", ram_d); else passed++;
        load_en = 1'b0;
        #1;
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        upd_valid = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (c % 3 == 0) begin
                dvtc = {8'd5, 8'd20, 8'd10}; d_last = 8'd3;
            end else begin
                dvtc = {3{8'h7F}}; d_last = 8'h81;
            end
            #1;
            checks++; if (upd_ready !== (c % 3 == 0))
                $display("FAIL b2b_ready_%0d: got %b want %b", c, upd_ready, (c % 3 == 0)); else passed++;
            tick();
            if (out_valid === 1'b1) pulses++;
            if (c % 3 == 1) begin
                checks++; if (ram_d !== 8'd29) $display("FAIL b2b_ram_d_%0d: got %0h want 1d", c, ram_d); else passed++;
            end
        end
        upd_valid = 1'b0;
        checks++; if (pulses !== 3) $display("FAIL b2b_pulses: got %0d want 3", pulses); else passed++;
    endtask

    task automatic test_reset_mid();
        dvtc = {3{8'h80}}; d_last = 8'h7F; upd_valid = 1'b1;
        tick();
        upd_valid = 1'b0;
        tick();
        checks++; if (ram_d !== SAT_NEG_EXP || sat_flag !== SAT_NEG_FLAG)
            $display("FAIL mid_pre: got ram=%0h sat=%b want %0h %b", ram_d, sat_flag, SAT_NEG_EXP, SAT_NEG_FLAG); else passed++;
        reset = 1'b1; load_en = 1'b1; sin = 1'b1; din = 8'd50; upd_valid = 1'b1;
        tick();
        checks++; if (ram_d !== 8'd0 || hard_bit !== 1'b0) $display("FAIL mid_ram: got ram=%0h hb=%b want 0 0", ram_d, hard_bit); else passed++;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || sat_flag !== 1'b0)
            $display("FAIL mid_ctrl: got ov=%b busy=%b sat=%b want 0 0 0", out_valid, busy, sat_flag); else passed++;
        checks++; if (upd_ready !== 1'b0) $display("FAIL mid_ready_load: got %b want 0", upd_ready); else passed++;
        reset = 1'b0; load_en = 1'b0; sin = 1'b0; upd_valid = 1'b0;
        #1;
        checks++; if (upd_ready !== 1'b1) $display("FAIL mid_ready: got %b want 1", upd_ready); else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_basic();
        test_saturation();
        test_load_abort();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
